// File: rtl/instruction_loader.sv
// -----------------------------------------------------------------------------
// instruction_loader
//   Writer side of the byte-wide instruction memory write port. Bytes arriving
//   from the debug unit's UART receive path are written sequentially into
//   instruction memory starting at address 0. A load ends on an aligned HALT
//   word or when the last memory location has been written.
//
// Ports
//   i_clock         system clock, rising edge
//   i_reset         synchronous active-high reset
//   i_start         one-cycle pulse, begins or restarts a load (IDLE/DONE only)
//   i_rx_data       received byte
//   i_rx_done       one-cycle strobe qualifying i_rx_data
//   o_write_enable  memory byte write strobe, one cycle per accepted byte
//   o_write_data    byte to write
//   o_write_addr    byte address to write
//   o_busy          high while loading
//   o_done          level, load finished (halt or overflow)
//   o_overflow      level, load ended by filling memory without a HALT
//   o_byte_count    bytes written in the current load, 0..MEMORY_DEPTH
// -----------------------------------------------------------------------------
module instruction_loader #(
  parameter int                        MEMORY_WIDTH     = 8,
  parameter int                        MEMORY_DEPTH     = 256,
  parameter int                        NB_ADDR_DEPTH    = 8,
  parameter int                        NB_INSTRUCTION   = 32,
  parameter logic [NB_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF
) (
  input  logic                     i_clock,
  input  logic                     i_reset,
  input  logic                     i_start,
  input  logic [MEMORY_WIDTH-1:0]  i_rx_data,
  input  logic                     i_rx_done,
  output logic                     o_write_enable,
  output logic [MEMORY_WIDTH-1:0]  o_write_data,
  output logic [NB_ADDR_DEPTH-1:0] o_write_addr,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_overflow,
  output logic [NB_ADDR_DEPTH:0]   o_byte_count
);

  // Only the three bytes preceding the current one are needed to assemble a word.
  localparam int NB_WORD_HIST = NB_INSTRUCTION - MEMORY_WIDTH;

  localparam logic [NB_ADDR_DEPTH-1:0] LAST_ADDR = NB_ADDR_DEPTH'(MEMORY_DEPTH - 1);
  localparam logic [NB_ADDR_DEPTH-1:0] ADDR_ONE  = NB_ADDR_DEPTH'(1);
  localparam logic [NB_ADDR_DEPTH:0]   COUNT_ONE = (NB_ADDR_DEPTH + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_r;
  logic [NB_ADDR_DEPTH-1:0] ptr_r;
  logic [NB_WORD_HIST-1:0]  word_r;
  logic                     halt_hit_s;
  logic                     last_addr_s;

  // True when the byte being received completes a word equal to the HALT marker.
  function automatic logic is_halt_word(
    input logic [1:0]              byte_lane,
    input logic [NB_WORD_HIST-1:0] history,
    input logic [MEMORY_WIDTH-1:0] new_byte
  );
    logic result;
    if (byte_lane == 2'b11) begin
      result = ({history, new_byte} == HALT_INSTRUCTION);
    end else begin
      result = 1'b0;
    end
    return result;
  endfunction

  // End-of-load conditions evaluated against the current pointer and byte.
  always_comb begin
    halt_hit_s  = is_halt_word(ptr_r[1:0], word_r, i_rx_data);
    if (ptr_r == LAST_ADDR) begin
      last_addr_s = 1'b1;
    end else begin
      last_addr_s = 1'b0;
    end
  end

  // Load FSM with registered write port and status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r        <= ST_IDLE;
      ptr_r          <= '0;
      word_r         <= '0;
      o_write_enable <= 1'b0;
      o_write_data   <= '0;
      o_write_addr   <= '0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_overflow     <= 1'b0;
      o_byte_count   <= '0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          // Received bytes are dropped here, including one coincident with i_start.
          o_write_enable <= 1'b0;
          if (i_start) begin
            state_r      <= ST_LOAD;
            ptr_r        <= '0;
            word_r       <= '0;
            o_write_data <= '0;
            o_write_addr <= '0;
            o_busy       <= 1'b1;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
            o_byte_count <= '0;
          end else begin
            state_r <= state_r;
          end
        end

        ST_LOAD: begin
          if (i_rx_done) begin
            o_write_enable <= 1'b1;
            o_write_data   <= i_rx_data;
            o_write_addr   <= ptr_r;
            ptr_r          <= ptr_r + ADDR_ONE;
            o_byte_count   <= o_byte_count + COUNT_ONE;
            word_r         <= {word_r[NB_WORD_HIST-MEMORY_WIDTH-1:0], i_rx_data};
            // HALT wins over overflow when the final word is the marker.
            if (halt_hit_s) begin
              state_r    <= ST_DONE;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              o_overflow <= 1'b0;
            end else if (last_addr_s) begin
              state_r    <= ST_DONE;
              o_busy     <= 1'b0;
              o_done     <= 1'b1;
              o_overflow <= 1'b1;
            end else begin
              state_r <= ST_LOAD;
            end
          end else begin
            o_write_enable <= 1'b0;
          end
        end

        default: begin
          state_r        <= ST_IDLE;
          o_write_enable <= 1'b0;
          o_busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule
